wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive B-pending cycles lost to A before a hold is forced.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- a_we  in  1  pipeline writeback request; cannot be backpressured.
- a_reg  in  5  pipeline writeback destination.
- a_data  in  32  pipeline writeback data.
- b_valid  in  1  multi-cycle unit result valid.
- b_ready  out  1  result accepted this cycle.
- b_reg  in  5  multi-cycle unit destination.
- b_data  in  32  multi-cycle unit data.
- issue_valid  in  1  multi-cycle operation issued.
- issue_reg  in  5  destination of the issued operation.
- chk_rs, chk_rt, chk_rd  in  5 each  decode operands to check.
- rs_busy, rt_busy, rd_busy  out  1 each  operand has a pending multi-cycle write.
- wb_hold  out  1  pipeline must not assert a_we next cycle.
- WriteReg  out  5  register file write address.
- writeData  out  32  register file write data.
- regWrite  out  1  register file write enable.

Function
REQ-003 SHALL hold a one-entry buffer (reg, data) with FSM states IDLE (empty) and PEND (full).
REQ-004 SHALL drive b_ready = 1 only in IDLE; b_valid & b_ready moves IDLE->PEND and captures b_reg/b_data.
REQ-005 SHALL drive the write port combinationally: if a_we, forward A (regWrite=1); else if PEND, forward the buffer (regWrite=1) and move PEND->IDLE at the next posedge; else regWrite=0, WriteReg=0, writeData=0.
REQ-006 SHALL give A absolute priority; a B write is never merged with or dropped for an A write.
REQ-007 SHALL not buffer-and-commit in the same cycle: the earliest B commit is the cycle after acceptance.
REQ-008 SHALL increment a starve counter each PEND cycle in which a_we=1, and clear it on any B commit or in IDLE.
REQ-009 SHALL assert wb_hold (registered) for exactly one cycle when the counter reaches STARVE_LIMIT, then clear the counter.
REQ-010 SHALL treat a_we=1 during a cycle following wb_hold as a protocol error: A still wins and the counter restarts.
REQ-011 SHALL keep a 32-bit busy vector: issue_valid sets busy[issue_reg]; a B commit clears busy[WriteReg].
REQ-012 SHALL let set win over clear when issue and commit target the same register in one cycle.
REQ-013 SHALL never set busy[0]; issues and commits to register 0 are otherwise processed normally, with no regfile effect.
REQ-014 SHALL derive rs_busy/rt_busy/rd_busy combinationally from the registered busy vector; index 0 always reads 0.

Reset
REQ-015 SHALL on rst: state=IDLE, buffer=0, busy=0, counter=0, wb_hold=0; b_ready=1 and regWrite=0 unless a_we=1.
REQ-016 SHALL discard a buffered result if rst is asserted mid-PEND; no regfile write occurs.

Configuration
REQ-017 SHALL, with WB_ARB_BYPASS_EN defined, mask a busy output to 0 when a B commit to that same register occurs in the same cycle.
- The decode stage then reads the value via the register file's same-cycle write-before-read.
- Without the macro, a busy bit clears visibly only at the next posedge.

Structure
REQ-018 SHALL take the register-index width (5), data width (32) and FSM state encoding from the shared package pipe_pkg.
REQ-019 SHALL keep the busy vector in a sub-module wb_scoreboard (set, clear, three check ports, and the bypass option).

Verification
REQ-020 SHALL cover:
- B result (reg 5, 0xDEADBEEF) with a_we=0 -> b_ready=0 the next cycle; regWrite=1, WriteReg=5 that cycle; IDLE after.
- a_we=1 (reg 3, 0x11) in the same cycle B commits (reg 7) -> port shows reg 3; reg 7 is written the next cycle without a_we.
- PEND with a_we=1 for 4 cycles -> wb_hold=1 in cycle 5; B commits in cycle 6.
- Issue reg 9 -> rs_busy=1 for chk_rs=9 until the commit cycle; busy=0 after. With the macro, 0 in the commit cycle itself.
- Issue reg 9 in the same cycle as a reg 9 commit -> busy stays 1.
- rst asserted in PEND -> no write; b_ready=1; all busy outputs 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, arbiter state encoding and register mask helper
package pipe_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } arb_state_e;

    // One-hot mask of a register index; register 0 never maps to a bit.
    function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != '0) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: A/B writeback, issue, operand check, regfile port
interface wb_arbiter_if;
    import pipe_pkg::*;

    logic              a_we;
    logic [REG_W-1:0]  a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [REG_W-1:0]  b_reg;
    logic [DATA_W-1:0] b_data;
    logic              issue_valid;
    logic [REG_W-1:0]  issue_reg;
    logic [REG_W-1:0]  chk_rs;
    logic [REG_W-1:0]  chk_rt;
    logic [REG_W-1:0]  chk_rd;
    logic              rs_busy;
    logic              rt_busy;
    logic              rd_busy;
    logic              wb_hold;
    logic [REG_W-1:0]  WriteReg;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;

    modport master (
        output a_we, a_reg, a_data, b_valid, b_reg, b_data,
               issue_valid, issue_reg, chk_rs, chk_rt, chk_rd,
        input  b_ready, rs_busy, rt_busy, rd_busy, wb_hold,
               WriteReg, writeData, regWrite
    );

    modport slave (
        input  a_we, a_reg, a_data, b_valid, b_reg, b_data,
               issue_valid, issue_reg, chk_rs, chk_rt, chk_rd,
        output b_ready, rs_busy, rt_busy, rd_busy, wb_hold,
               WriteReg, writeData, regWrite
    );

endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write busy vector with three check ports; WB_ARB_BYPASS_EN masks same-cycle commits
module wb_scoreboard
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             setEn,
    input  logic [REG_W-1:0] setReg,
    input  logic             clrEn,
    input  logic [REG_W-1:0] clrReg,
    input  logic [REG_W-1:0] chkRs,
    input  logic [REG_W-1:0] chkRt,
    input  logic [REG_W-1:0] chkRd,
    output logic             rsBusy,
    output logic             rtBusy,
    output logic             rdBusy
);

    logic [NUM_REGS-1:0] busy;

    function automatic logic busyAt(input logic [NUM_REGS-1:0] v, input logic [REG_W-1:0] r);
        return (r != '0) && v[r];
    endfunction

    // Set is OR-ed in after the clear so a same-cycle issue keeps the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~(clrEn ? regMask(clrReg) : '0))
                  | (setEn ? regMask(setReg) : '0);
        end
    end

`ifdef WB_ARB_BYPASS_EN
    // The regfile writes before it is read, so a committing register is already safe.
    assign rsBusy = busyAt(busy, chkRs) & ~(clrEn && (clrReg == chkRs));
    assign rtBusy = busyAt(busy, chkRt) & ~(clrEn && (clrReg == chkRt));
    assign rdBusy = busyAt(busy, chkRd) & ~(clrEn && (clrReg == chkRd));
`else
    assign rsBusy = busyAt(busy, chkRs);
    assign rtBusy = busyAt(busy, chkRt);
    assign rdBusy = busyAt(busy, chkRd);
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - regfile write-port arbiter: pipeline A has priority, one-entry buffer for unit B, starvation hold
module wb_arbiter
    import pipe_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state;
    logic [REG_W-1:0]  bufReg;
    logic [DATA_W-1:0] bufData;
    logic [CNT_W-1:0]  starveCnt;
    logic              wbHoldQ;
    logic              bReadyQ;
    logic              bCommit;

    assign bCommit     = (state == PEND) && !bus.a_we;
    assign bus.b_ready = bReadyQ;
    assign bus.wb_hold = wbHoldQ;

    always_comb begin
        bus.regWrite  = 1'b0;
        bus.WriteReg  = '0;
        bus.writeData = '0;
        if (bus.a_we) begin
            bus.regWrite  = 1'b1;
            bus.WriteReg  = bus.a_reg;
            bus.writeData = bus.a_data;
        end else if (state == PEND) begin
            bus.regWrite  = 1'b1;
            bus.WriteReg  = bufReg;
            bus.writeData = bufData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bufReg    <= '0;
            bufData   <= '0;
            starveCnt <= '0;
            wbHoldQ   <= 1'b0;
            bReadyQ   <= 1'b1;
        end else begin
            wbHoldQ <= 1'b0;
            case (state)
                IDLE: begin
                    starveCnt <= '0;
                    if (bus.b_valid) begin
                        state   <= PEND;
                        bReadyQ <= 1'b0;
                        bufReg  <= bus.b_reg;
                        bufData <= bus.b_data;
                    end
                end
                PEND: begin
                    if (!bus.a_we) begin
                        state     <= IDLE;
                        bReadyQ   <= 1'b1;
                        starveCnt <= '0;
                    end else if (starveCnt == CNT_W'(STARVE_LIMIT - 1)) begin
                        // Hold lands in the next cycle; the cycle after it is free for B.
                        wbHoldQ   <= 1'b1;
                        starveCnt <= '0;
                    end else begin
                        starveCnt <= starveCnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bReadyQ <= 1'b1;
                end
            endcase
        end
    end

    wb_scoreboard u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .setEn  (bus.issue_valid),
        .setReg (bus.issue_reg),
        .clrEn  (bCommit),
        .clrReg (bufReg),
        .chkRs  (bus.chk_rs),
        .chkRt  (bus.chk_rt),
        .chkRd  (bus.chk_rd),
        .rsBusy (bus.rs_busy),
        .rtBusy (bus.rt_busy),
        .rdBusy (bus.rd_busy)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector table plus starvation sequence for wb_arbiter
module tb_wb_arbiter;

`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          r;
        bit          awe;
        logic [4:0]  areg;
        logic [31:0] adata;
        bit          bv;
        logic [4:0]  breg;
        logic [31:0] bdata;
        bit          iv;
        logic [4:0]  ireg;
        logic [4:0]  rs, rt, rd;
        bit          eBr, eRw;
        logic [4:0]  eWr;
        logic [31:0] eWd;
        bit          eHold, eRs, eRt, eRd;
    } vec_t;

    vec_t tbl[$];
    int   nVec = 0;
    int   nMis = 0;

    function automatic vec_t mk(bit r, bit awe, logic [4:0] areg, logic [31:0] adata,
                                bit bv, logic [4:0] breg, logic [31:0] bdata,
                                bit iv, logic [4:0] ireg,
                                logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                bit eBr, bit eRw, logic [4:0] eWr, logic [31:0] eWd,
                                bit eHold, bit eRs, bit eRt, bit eRd);
        vec_t v;
        v.r = r; v.awe = awe; v.areg = areg; v.adata = adata;
        v.bv = bv; v.breg = breg; v.bdata = bdata;
        v.iv = iv; v.ireg = ireg; v.rs = rs; v.rt = rt; v.rd = rd;
        v.eBr = eBr; v.eRw = eRw; v.eWr = eWr; v.eWd = eWd;
        v.eHold = eHold; v.eRs = eRs; v.eRt = eRt; v.eRd = eRd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst             = v.r;
        bus.a_we        = v.awe;
        bus.a_reg       = v.areg;
        bus.a_data      = v.adata;
        bus.b_valid     = v.bv;
        bus.b_reg       = v.breg;
        bus.b_data      = v.bdata;
        bus.issue_valid = v.iv;
        bus.issue_reg   = v.ireg;
        bus.chk_rs      = v.rs;
        bus.chk_rt      = v.rt;
        bus.chk_rd      = v.rd;
    endtask

    task automatic check(input vec_t v, input int idx);
        chk("b_ready",   idx, 32'(bus.b_ready),  32'(v.eBr));
        chk("regWrite",  idx, 32'(bus.regWrite), 32'(v.eRw));
        chk("WriteReg",  idx, 32'(bus.WriteReg), 32'(v.eWr));
        chk("writeData", idx, bus.writeData,     v.eWd);
        chk("wb_hold",   idx, 32'(bus.wb_hold),  32'(v.eHold));
        chk("rs_busy",   idx, 32'(bus.rs_busy),  32'(v.eRs));
        chk("rt_busy",   idx, 32'(bus.rt_busy),  32'(v.eRt));
        chk("rd_busy",   idx, 32'(bus.rd_busy),  32'(v.eRd));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // reset behaviour
        tbl.push_back(mk(1,0,0,0,           0,0,0,            0,0, 0,0,0,    1,0,0,0,            0,0,0,0));
        tbl.push_back(mk(1,1,2,32'h22,      0,0,0,            0,0, 0,0,0,    1,1,2,32'h22,       0,0,0,0));
        // B result with A idle
        tbl.push_back(mk(0,0,0,0,           1,5,32'hDEADBEEF, 0,0, 0,0,0,    1,0,0,0,            0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,0,0,    0,1,5,32'hDEADBEEF, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,0,0,    1,0,0,0,            0,0,0,0));
        // A wins over a pending B
        tbl.push_back(mk(0,0,0,0,           1,7,32'h77,       0,0, 0,0,0,    1,0,0,0,            0,0,0,0));
        tbl.push_back(mk(0,1,3,32'h11,      0,0,0,            0,0, 0,0,0,    0,1,3,32'h11,       0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,0,0,    0,1,7,32'h77,       0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,0,0,    1,0,0,0,            0,0,0,0));
        // starvation: 4 lost cycles, hold in cycle 5, commit in cycle 6
        tbl.push_back(mk(0,0,0,0,           1,8,32'h88,       0,0, 0,0,0,    1,0,0,0,            0,0,0,0));
        tbl.push_back(mk(0,1,10,32'hA0,     0,0,0,            0,0, 0,0,0,    0,1,10,32'hA0,      0,0,0,0));
        tbl.push_back(mk(0,1,11,32'hA1,     0,0,0,            0,0, 0,0,0,    0,1,11,32'hA1,      0,0,0,0));
        tbl.push_back(mk(0,1,12,32'hA2,     0,0,0,            0,0, 0,0,0,    0,1,12,32'hA2,      0,0,0,0));
        tbl.push_back(mk(0,1,13,32'hA3,     0,0,0,            0,0, 0,0,0,    0,1,13,32'hA3,      0,0,0,0));
        tbl.push_back(mk(0,1,4,32'h44,      0,0,0,            0,0, 0,0,0,    0,1,4,32'h44,       1,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,0,0,    0,1,8,32'h88,       0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,0,0,    1,0,0,0,            0,0,0,0));
        // busy tracking for reg 9
        tbl.push_back(mk(0,0,0,0,           0,0,0,            1,9, 9,9,0,    1,0,0,0,            0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           1,9,32'h99,       0,0, 9,9,0,    1,0,0,0,            0,1,1,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 9,9,0,    0,1,9,32'h99,       0,!BYP,!BYP,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 9,9,0,    1,0,0,0,            0,0,0,0));
        // re-issue in the commit cycle keeps reg 9 busy
        tbl.push_back(mk(0,0,0,0,           0,0,0,            1,9, 0,9,0,    1,0,0,0,            0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           1,9,32'h55,       0,0, 0,9,0,    1,0,0,0,            0,0,1,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            1,9, 0,9,0,    0,1,9,32'h55,       0,0,!BYP,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,9,0,    1,0,0,0,            0,0,1,0));
        // register 0: issue ignored by the scoreboard, commit still goes out
        tbl.push_back(mk(0,0,0,0,           1,0,32'hAB,       1,0, 0,0,0,    1,0,0,0,            0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,0,0,    0,1,0,32'hAB,       0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 0,9,0,    1,0,0,0,            0,0,1,0));
        // reset in PEND discards the buffer and clears busy
        tbl.push_back(mk(0,0,0,0,           1,12,32'hC0,      1,12, 0,9,12,  1,0,0,0,            0,0,1,0));
        tbl.push_back(mk(0,1,2,32'h22,      0,0,0,            0,0, 0,9,12,   0,1,2,32'h22,       0,0,1,1));
        tbl.push_back(mk(1,0,0,0,           0,0,0,            0,0, 9,9,12,   1,0,0,0,            0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,            0,0, 9,9,12,   1,0,0,0,            0,0,0,0));

        v = tbl[0];
        drive(v);
        step();
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #3;
            check(tbl[i], i);
            step();
        end

        // A keeps writing past the hold: hold recurs every 4 lost cycles, then B commits
        v = mk(0,0,0,0, 1,20,32'h2020, 0,0, 0,0,0, 1,0,0,0, 0,0,0,0);
        drive(v);
        #3;
        check(v, 100);
        step();
        for (int c = 1; c <= 9; c++) begin
            v = mk(0,1,5'(c),32'(c) * 32'h101, 0,0,0, 0,0, 0,0,0,
                   0,1,5'(c),32'(c) * 32'h101, (c == 5) || (c == 9),0,0,0);
            drive(v);
            #3;
            check(v, 100 + c);
            step();
        end
        v = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,1,20,32'h2020, 0,0,0,0);
        drive(v);
        #3;
        check(v, 110);
        step();
        v = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0, 0,0,0,0);
        drive(v);
        #3;
        check(v, 111);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
